bitwise_logic_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit for the ALU datapath: the next generation of the fixed 32-bit combinational OR, generalised to any WIDTH and to eight logic ops. Operands enter through a valid/ready handshake, pass through a two-stage, back-pressurable pipeline with an operation tag, and leave with result flags. Sits beside the adder and shifter; the ALU result mux consumes its output.

---
 rtl/bitwise_logic_pipe.sv | 168 ++++++++++++++++
 tb/tb_bitwise_logic_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_logic_pipe
//  Brief    : Two-stage, back-pressurable bitwise logic unit (8 ops) with
//             tag passthrough, zero/ones flags, optional popcount and a
//             completed-operation counter.
//  Options  : BITWISE_LOGIC_POPCNT_EN - when defined, stage 2 registers the
//             population count of the result into out_popcnt; otherwise
//             out_popcnt is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module bitwise_logic_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_op,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_result,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_zero,
  output logic                         out_ones,
  output logic [$clog2(WIDTH+1)-1:0]   out_popcnt,
  output logic [CNT_W-1:0]             op_count
);

  localparam int PC_W = $clog2(WIDTH + 1);

  localparam logic [2:0] c_opAnd  = 3'b000;
  localparam logic [2:0] c_opOr   = 3'b001;
  localparam logic [2:0] c_opXor  = 3'b010;
  localparam logic [2:0] c_opNor  = 3'b011;
  localparam logic [2:0] c_opNand = 3'b100;
  localparam logic [2:0] c_opXnor = 3'b101;
  localparam logic [2:0] c_opAndn = 3'b110;

  // Stage 1 holding registers
  logic             r_s1Valid;
  logic [2:0]       r_s1Op;
  logic [WIDTH-1:0] r_s1A;
  logic [WIDTH-1:0] r_s1B;
  logic [TAG_W-1:0] r_s1Tag;

  // Stage 2 (output) registers
  logic             r_s2Valid;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_zero;
  logic             r_ones;
  logic [CNT_W-1:0] r_opCount;

  logic             w_inFire;
  logic             w_outFire;
  logic             w_s2Load;
  logic [WIDTH-1:0] w_result;

  // S1 may only be refilled when its content is leaving (or it is empty), so
  // in_ready mirrors the S2 load condition whenever S1 is occupied.
  assign in_ready  = !r_s1Valid || !r_s2Valid || out_ready;
  assign w_inFire  = in_valid && in_ready;
  assign w_outFire = r_s2Valid && out_ready;
  assign w_s2Load  = r_s1Valid && (!r_s2Valid || out_ready);

  // Stage 1 register: capture operands on every accepted beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1Valid <= 1'b0;
      r_s1Op    <= 3'b000;
      r_s1A     <= '0;
      r_s1B     <= '0;
      r_s1Tag   <= '0;
    end else if (w_inFire) begin
      r_s1Valid <= 1'b1;
      r_s1Op    <= in_op;
      r_s1A     <= in_a;
      r_s1B     <= in_b;
      r_s1Tag   <= in_tag;
    end else if (w_s2Load) begin
      r_s1Valid <= 1'b0;
    end
  end

  // Bitwise operation decode on stage-1 contents
  always_comb begin
    w_result = r_s1A;
    case (r_s1Op)
      c_opAnd:  w_result = r_s1A & r_s1B;
      c_opOr:   w_result = r_s1A | r_s1B;
      c_opXor:  w_result = r_s1A ^ r_s1B;
      c_opNor:  w_result = ~(r_s1A | r_s1B);
      c_opNand: w_result = ~(r_s1A & r_s1B);
      c_opXnor: w_result = ~(r_s1A ^ r_s1B);
      c_opAndn: w_result = r_s1A & ~r_s1B;
      default:  w_result = r_s1A;
    endcase
  end

  // Stage 2 register: result, tag and flags; holds while stalled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2Valid <= 1'b0;
      r_result  <= '0;
      r_tag     <= '0;
      r_zero    <= 1'b1;
      r_ones    <= 1'b0;
    end else if (w_s2Load) begin
      r_s2Valid <= 1'b1;
      r_result  <= w_result;
      r_tag     <= r_s1Tag;
      r_zero    <= (w_result == '0);
      r_ones    <= &w_result;
    end else if (w_outFire) begin
      r_s2Valid <= 1'b0;
    end
  end

`ifdef BITWISE_LOGIC_POPCNT_EN
  logic [PC_W-1:0] w_popcnt;
  logic [PC_W-1:0] r_popcnt;

  // Population count of the stage-2 bound result
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + {{(PC_W-1){1'b0}}, w_result[i]};
    end
  end

  // Popcount register loads alongside the other stage-2 flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_popcnt <= '0;
    end else if (w_s2Load) begin
      r_popcnt <= w_popcnt;
    end
  end

  assign out_popcnt = r_popcnt;
`else
  assign out_popcnt = '0;
`endif

  // Completed-handshake counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_opCount <= '0;
    end else if (w_outFire) begin
      r_opCount <= r_opCount + CNT_W'(1);
    end
  end

  assign out_valid  = r_s2Valid;
  assign out_result = r_result;
  assign out_tag    = r_tag;
  assign out_zero   = r_zero;
  assign out_ones   = r_ones;
  assign op_count   = r_opCount;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_bitwise_logic_pipe
//  Brief    : Scoreboard bench for bitwise_logic_pipe (WIDTH=32) plus a
//             CNT_W=4 instance sharing the same stimulus for counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_logic_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int PC_W  = $clog2(WIDTH + 1);

  logic              clock   = 1'b0;
  logic              reset_n = 1'b1;
  logic              in_valid = 1'b0;
  logic [2:0]        in_op    = 3'b000;
  logic [WIDTH-1:0]  in_a     = '0;
  logic [WIDTH-1:0]  in_b     = '0;
  logic [TAG_W-1:0]  in_tag   = '0;
  logic              out_ready = 1'b1;

  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_zero;
  logic              out_ones;
  logic [PC_W-1:0]   out_popcnt;
  logic [15:0]       op_count;

  logic              inReady4;
  logic              outValid4;
  logic [WIDTH-1:0]  outResult4;
  logic [TAG_W-1:0]  outTag4;
  logic              outZero4;
  logic              outOnes4;
  logic [PC_W-1:0]   outPopcnt4;
  logic [3:0]        opCount4;

  bitwise_logic_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_zero(out_zero), .out_ones(out_ones),
    .out_popcnt(out_popcnt), .op_count(op_count)
  );

  bitwise_logic_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(inReady4), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(outValid4), .out_ready(out_ready),
    .out_result(outResult4), .out_tag(outTag4),
    .out_zero(outZero4), .out_ones(outOnes4),
    .out_popcnt(outPopcnt4), .op_count(opCount4)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
    int               expCyc;
  } exp_t;

  exp_t             sbQ[$];
  int               nCompared = 0;
  int               nMism     = 0;
  int               cyc       = 0;
  int               modelCnt  = 0;
  bit               latCheck  = 1'b0;
  bit               prevStall = 1'b0;
  logic [WIDTH-1:0] prevRes;
  logic [TAG_W-1:0] prevTag;
  exp_t             mEntry;
  logic [PC_W-1:0]  expPop;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMism++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one beat until accepted; expected result goes to the scoreboard at accept.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                      input logic [WIDTH-1:0] expRes, output int waited);
    exp_t e;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        e.res    = expRes;
        e.tag    = tag;
        e.expCyc = latCheck ? cyc + 2 : -1;
        sbQ.push_back(e);
        @(posedge clock); #1;
        break;
      end
      waited++;
      if (waited > 50) begin
        chk("accept_timeout", 1, 0);
        break;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sbQ.size() != 0) chk("drain_timeout", sbQ.size(), 0);
    @(posedge clock); #1;
  endtask

  // Asynchronous reset assertion mid-cycle, immediate output checks, release away from posedge.
  task automatic doReset();
    @(posedge clock); #3;
    reset_n  = 1'b0;
    sbQ.delete();
    modelCnt = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_zero", out_zero, 1);
    chk("rst_out_ones", out_ones, 0);
    chk("rst_out_popcnt", out_popcnt, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_op_count_w4", opCount4, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  // Monitor: pop and compare on every output handshake; check hold under stall.
  always @(negedge clock) begin
    if (!reset_n) begin
      prevStall = 1'b0;
    end else begin
      if (out_valid && prevStall) begin
        chk("hold_result", out_result, prevRes);
        chk("hold_tag", out_tag, prevTag);
      end
      if (out_valid && out_ready) begin
        chk("op_count", op_count, modelCnt[15:0]);
        chk("op_count_w4", opCount4, modelCnt[3:0]);
        if (sbQ.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          mEntry = sbQ.pop_front();
`ifdef BITWISE_LOGIC_POPCNT_EN
          expPop = PC_W'($countones(mEntry.res));
`else
          expPop = '0;
`endif
          chk("result", out_result, mEntry.res);
          chk("tag", out_tag, mEntry.tag);
          chk("zero_flag", out_zero, (mEntry.res == '0));
          chk("ones_flag", out_ones, (&mEntry.res));
          chk("popcnt", out_popcnt, expPop);
          if (mEntry.expCyc >= 0) chk("latency", cyc, mEntry.expCyc);
        end
        modelCnt++;
      end
      prevStall = out_valid && !out_ready;
      prevRes   = out_result;
      prevTag   = out_tag;
    end
  end

  logic [2:0]       swOp  [8];
  logic [WIDTH-1:0] swExp [8];

  initial begin
    int w;
    int stalls;
    swOp  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    swExp = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h000F_0000,
              32'hFF0F_EDCB, 32'h00FF_1234, 32'hF000_0000, 32'hF0F0_1234};

    doReset();

    // Op sweep, tags 0..7, 2-cycle latency
    latCheck  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(swOp[i], 32'hF0F0_1234, 32'h0FF0_FFFF, TAG_W'(i), swExp[i], w);
    end
    // Flags
    send(3'd0, 32'hAAAA_AAAA, 32'h5555_5555, 5'd8, 32'h0000_0000, w);
    send(3'd1, 32'hAAAA_AAAA, 32'h5555_5555, 5'd9, 32'hFFFF_FFFF, w);
    drain();

    // Back-pressure: two beats accepted, third refused until out_ready rises
    latCheck  = 1'b0;
    out_ready = 1'b0;
    send(3'd1, 32'h0000_00FF, 32'h0000_FF00, 5'd10, 32'h0000_FFFF, w);
    chk("bp_accept0_wait", w, 0);
    send(3'd2, 32'hFFFF_FFFF, 32'h1234_5678, 5'd11, 32'hEDCB_A987, w);
    chk("bp_accept1_wait", w, 0);
    in_valid = 1'b1;
    in_op    = 3'd4;
    in_a     = 32'hFFFF_0000;
    in_b     = 32'hFF00_FF00;
    in_tag   = 5'd12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    send(3'd4, 32'hFFFF_0000, 32'hFF00_FF00, 5'd12, 32'h00FF_FFFF, w);
    chk("bp_ready_same_cycle", w, 0);
    send(3'd6, 32'h1234_5678, 32'h0000_FFFF, 5'd13, 32'h1234_0000, w);
    drain();
    chk("bp_count_after", op_count, 16'd14);

    // Reset while two beats are held in a stall
    out_ready = 1'b0;
    send(3'd7, 32'hDEAD_BEEF, 32'h0, 5'd20, 32'hDEAD_BEEF, w);
    send(3'd7, 32'hCAFE_F00D, 32'h0, 5'd21, 32'hCAFE_F00D, w);
    doReset();
    out_ready = 1'b1;
    @(negedge clock);
    chk("no_stale_valid", out_valid, 0);
    @(posedge clock); #1;
    latCheck = 1'b1;
    send(3'd5, 32'h0F0F_0F0F, 32'h00FF_00FF, 5'd22, 32'hF00F_F00F, w);
    drain();
    chk("post_rst_count", op_count, 16'd1);

    // Throughput: 100 back-to-back beats from a clean reset
    doReset();
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      send(3'd2, WIDTH'(i), 32'hFFFF_0000, TAG_W'(i), 32'hFFFF_0000 | WIDTH'(i), w);
      stalls += w;
    end
    chk("tp_stalls", stalls, 0);
    drain();
    chk("tp_op_count", op_count, 16'd100);
    chk("tp_op_count_w4", opCount4, 4'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMism);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
